// File: rtl/mac_pkg.sv
// Shared defaults and state type for the MAC operand sequencer.
package mac_pkg;

  localparam int unsigned MAC_DW_DEF   = 8;
  localparam int unsigned MAC_ACCW_DEF = 16;
  localparam int unsigned MAC_LAT      = 3;
  localparam int unsigned MAC_CNTW_DEF = 8;

  typedef enum logic [1:0] {
    ACCUM  = 2'd0,
    DRAIN  = 2'd1,
    RESULT = 2'd2
  } mac_seq_state_t;

endpackage

// File: rtl/mac_seq.sv
// Feeds operand pairs to the 8x8 MAC, aligns its clear with the first pair,
// waits out the MAC pipeline and returns one dot-product result per vector.
module mac_seq #(
  parameter int unsigned DW      = mac_pkg::MAC_DW_DEF,
  parameter int unsigned ACCW    = mac_pkg::MAC_ACCW_DEF,
  parameter int unsigned MAC_LAT = mac_pkg::MAC_LAT,
  parameter int unsigned CNTW    = mac_pkg::MAC_CNTW_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            s_valid,
  output logic            s_ready,
  input  logic [DW-1:0]   s_a,
  input  logic [DW-1:0]   s_b,
  input  logic            s_last,
  output logic [DW-1:0]   mac_a,
  output logic [DW-1:0]   mac_b,
  output logic            mac_reset,
  input  logic [ACCW-1:0] mac_z,
  output logic            m_valid,
  input  logic            m_ready,
  output logic [ACCW-1:0] m_z,
  output logic [CNTW-1:0] m_count
);
  import mac_pkg::*;

  localparam int unsigned DCW = $clog2(MAC_LAT + 1);

  mac_seq_state_t  state_q, state_d;
  logic            first_q, first_d;
  logic            s_ready_q, s_ready_d;
  logic [DW-1:0]   mac_a_q, mac_a_d;
  logic [DW-1:0]   mac_b_q, mac_b_d;
  logic            mac_reset_q, mac_reset_d;
  logic [CNTW-1:0] beat_cnt_q, beat_cnt_d;
  logic [DCW-1:0]  drain_cnt_q, drain_cnt_d;
  logic            m_valid_q, m_valid_d;
  logic [ACCW-1:0] m_z_q, m_z_d;
  logic [CNTW-1:0] m_count_q, m_count_d;

  // Next-state and output logic; idle cycles push zero operands into the MAC.
  always_comb begin
    state_d     = state_q;
    first_d     = first_q;
    mac_a_d     = '0;
    mac_b_d     = '0;
    mac_reset_d = 1'b0;
    beat_cnt_d  = beat_cnt_q;
    drain_cnt_d = drain_cnt_q;
    m_valid_d   = m_valid_q;
    m_z_d       = m_z_q;
    m_count_d   = m_count_q;

    case (state_q)
      ACCUM: begin
        if (s_valid && s_ready_q) begin
          mac_a_d     = s_a;
          mac_b_d     = s_b;
          mac_reset_d = first_q;
          first_d     = 1'b0;
          if (first_q) begin
            beat_cnt_d = CNTW'(1);
          end else if (beat_cnt_q != {CNTW{1'b1}}) begin
            beat_cnt_d = beat_cnt_q + CNTW'(1);
          end
          if (s_last) begin
            state_d     = DRAIN;
            drain_cnt_d = DCW'(MAC_LAT);
          end
        end
      end
      DRAIN: begin
        if (drain_cnt_q == '0) begin
          m_z_d     = mac_z;
          m_count_d = beat_cnt_q;
          m_valid_d = 1'b1;
          state_d   = RESULT;
        end else begin
          drain_cnt_d = drain_cnt_q - DCW'(1);
        end
      end
      RESULT: begin
        if (m_ready) begin
          m_valid_d = 1'b0;
          first_d   = 1'b1;
          state_d   = ACCUM;
        end
      end
      default: begin
        state_d = ACCUM;
      end
    endcase

    // Registered ready follows the state being entered, so it rises the cycle after a result handshake.
    s_ready_d = (state_d == ACCUM);
  end

  // State register; reset holds the MAC in clear so the next vector starts from zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ACCUM;
      first_q     <= 1'b1;
      s_ready_q   <= 1'b0;
      mac_a_q     <= '0;
      mac_b_q     <= '0;
      mac_reset_q <= 1'b1;
      beat_cnt_q  <= '0;
      drain_cnt_q <= '0;
      m_valid_q   <= 1'b0;
      m_z_q       <= '0;
      m_count_q   <= '0;
    end else begin
      state_q     <= state_d;
      first_q     <= first_d;
      s_ready_q   <= s_ready_d;
      mac_a_q     <= mac_a_d;
      mac_b_q     <= mac_b_d;
      mac_reset_q <= mac_reset_d;
      beat_cnt_q  <= beat_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      m_valid_q   <= m_valid_d;
      m_z_q       <= m_z_d;
      m_count_q   <= m_count_d;
    end
  end

  assign s_ready   = s_ready_q;
  assign mac_a     = mac_a_q;
  assign mac_b     = mac_b_q;
  assign mac_reset = mac_reset_q;
  assign m_valid   = m_valid_q;
  assign m_z       = m_z_q;
  assign m_count   = m_count_q;

endmodule

// File: tb/tb_mac_seq.sv
// Directed bench for mac_seq paired with a behavioural 3-cycle 8x8 signed MAC.
module tb_mac_seq;

  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        s_valid;
  logic        s_ready;
  logic [7:0]  s_a;
  logic [7:0]  s_b;
  logic        s_last;
  logic [7:0]  mac_a;
  logic [7:0]  mac_b;
  logic        mac_reset;
  logic [15:0] mac_z;
  logic        m_valid;
  logic        m_ready;
  logic [15:0] m_z;
  logic [7:0]  m_count;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mac_seq dut (
    .clk(clk), .reset(reset),
    .s_valid(s_valid), .s_ready(s_ready), .s_a(s_a), .s_b(s_b), .s_last(s_last),
    .mac_a(mac_a), .mac_b(mac_b), .mac_reset(mac_reset), .mac_z(mac_z),
    .m_valid(m_valid), .m_ready(m_ready), .m_z(m_z), .m_count(m_count)
  );

  // MAC partner: accumulate (cleared by mac_reset on the loading edge), then two output stages.
  logic [15:0] acc, z1, z2;
  logic [15:0] pa, pb;
  assign pa = {{8{mac_a[7]}}, mac_a};
  assign pb = {{8{mac_b[7]}}, mac_b};
  always @(posedge clk) begin
    acc <= (mac_reset ? 16'h0000 : acc) + 16'(pa * pb);
    z1  <= acc;
    z2  <= z1;
  end
  assign mac_z = z2;

  typedef struct {
    string            name;
    int               nbeats;
    int               gap;
    logic [2:0][7:0]  a;
    logic [2:0][7:0]  b;
    logic [15:0]      exp_z;
    logic [7:0]       exp_cnt;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one pair, waits (bounded) for acceptance and checks the registered MAC drive.
  task automatic drive_beat(input logic [7:0] a, input logic [7:0] b, input logic last,
                            input logic first, output int acc_cyc);
    int t = 0;
    s_valid = 1'b1; s_a = a; s_b = b; s_last = last;
    while (!s_ready && t < 50) begin step(); t++; end
    if (!s_ready) check("s_ready_timeout", 32'(s_ready), 32'd1);
    step();
    acc_cyc = cyc;
    s_valid = 1'b0; s_last = 1'b0; s_a = 8'h00; s_b = 8'h00;
    check("mac_a_beat", 32'(mac_a), 32'(a));
    check("mac_b_beat", 32'(mac_b), 32'(b));
    check("mac_reset_beat", 32'(mac_reset), 32'(first));
  endtask

  task automatic wait_result(input string name, input logic [15:0] ez, input logic [7:0] ec,
                             input int acc_cyc);
    int t = 0;
    while (!m_valid && t < 20) begin step(); t++; end
    check({name, "_m_valid"}, 32'(m_valid), 32'd1);
    check({name, "_latency"}, 32'(cyc - acc_cyc), 32'(LAT + 1));
    check({name, "_m_z"}, 32'(m_z), 32'(ez));
    check({name, "_m_count"}, 32'(m_count), 32'(ec));
    check({name, "_s_ready_low"}, 32'(s_ready), 32'd0);
  endtask

  task automatic handshake(input string name);
    m_ready = 1'b1;
    step();
    check({name, "_m_valid_drop"}, 32'(m_valid), 32'd0);
    check({name, "_s_ready_rise"}, 32'(s_ready), 32'd1);
  endtask

  task automatic run_vector(input vec_t v);
    int ac = 0;
    for (int i = 0; i < v.nbeats; i++) begin
      drive_beat(v.a[i], v.b[i], (i == v.nbeats - 1), (i == 0), ac);
      if (i != v.nbeats - 1) begin
        for (int g = 0; g < v.gap; g++) begin
          step();
          check({v.name, "_idle_mac_a"}, 32'(mac_a), 32'd0);
          check({v.name, "_idle_mac_b"}, 32'(mac_b), 32'd0);
          check({v.name, "_idle_mac_reset"}, 32'(mac_reset), 32'd0);
        end
      end
    end
    wait_result(v.name, v.exp_z, v.exp_cnt, ac);
    handshake(v.name);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int ac;
    int seen;
    vec_t v;

    vecs[0] = '{"b2b",    3, 0, {8'd7,   8'hFE, 8'd3},   {8'hFF, 8'd5,  8'd4},   16'hFFFB, 8'd3};
    vecs[1] = '{"gap2",   3, 2, {8'd7,   8'hFE, 8'd3},   {8'hFF, 8'd5,  8'd4},   16'hFFFB, 8'd3};
    vecs[2] = '{"wrap",   3, 0, {8'h80,  8'h80, 8'h80},  {8'h80, 8'h80, 8'h80},  16'hC000, 8'd3};
    vecs[3] = '{"mixed",  2, 1, {8'd0,   8'd4,  8'd5},   {8'd0,  8'd4,  8'hFD},  16'h0001, 8'd2};
    vecs[4] = '{"single", 1, 0, {8'd0,   8'd0,  8'h83},  {8'd0,  8'd0,  8'h05},  16'hFD8F, 8'd1};

    reset = 1'b1; s_valid = 1'b0; s_a = 8'h00; s_b = 8'h00; s_last = 1'b0; m_ready = 1'b1;
    repeat (3) step();
    check("rst_s_ready", 32'(s_ready), 32'd0);
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_mac_reset", 32'(mac_reset), 32'd1);
    check("rst_mac_a", 32'(mac_a), 32'd0);
    check("rst_mac_b", 32'(mac_b), 32'd0);
    check("rst_m_z", 32'(m_z), 32'd0);
    check("rst_m_count", 32'(m_count), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 5; i++) run_vector(vecs[i]);

    // Single beat held by backpressure, then a fresh vector must show no residue.
    m_ready = 1'b0;
    drive_beat(8'hFF, 8'h01, 1'b1, 1'b1, ac);
    wait_result("hold", 16'hFFFF, 8'd1, ac);
    for (int i = 0; i < 5; i++) begin
      step();
      check("hold_m_valid", 32'(m_valid), 32'd1);
      check("hold_m_z", 32'(m_z), 32'hFFFF);
      check("hold_m_count", 32'(m_count), 32'd1);
      check("hold_s_ready", 32'(s_ready), 32'd0);
    end
    handshake("hold");
    v = '{"after_hold", 1, 0, {8'd0, 8'd0, 8'd2}, {8'd0, 8'd0, 8'd2}, 16'h0004, 8'd1};
    run_vector(v);

    // Reset after two beats abandons the vector.
    drive_beat(8'd10, 8'd10, 1'b0, 1'b1, ac);
    drive_beat(8'd10, 8'd10, 1'b0, 1'b0, ac);
    reset = 1'b1;
    step();
    check("abort_m_valid", 32'(m_valid), 32'd0);
    check("abort_mac_reset", 32'(mac_reset), 32'd1);
    check("abort_s_ready", 32'(s_ready), 32'd0);
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (m_valid) seen++;
    end
    check("abort_no_result", 32'(seen), 32'd0);
    v = '{"post_abort", 1, 0, {8'd0, 8'd0, 8'd1}, {8'd0, 8'd0, 8'd1}, 16'h0001, 8'd1};
    run_vector(v);

    // 300-beat vector: sum keeps counting, beat count saturates.
    for (int i = 0; i < 300; i++) drive_beat(8'd1, 8'd1, (i == 299), (i == 0), ac);
    wait_result("sat", 16'd300, 8'd255, ac);
    handshake("sat");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mac_seq.md
Name: mac_seq

Overview:
Sequencer that drives the operand/clear side of the team's 8x8 signed multiply-accumulate unit. It takes a valid/ready stream of operand pairs framed by a last flag, and drives the MAC's a, b and reset inputs with the correct alignment. It waits out the MAC pipeline, then captures the MAC's z output and presents one dot-product result per vector on a valid/ready output. The block sits between the operand fetch logic and the MAC instance.

Parameters:
DW, 8, operand width (signed), matches the MAC a/b width
ACCW, 16, accumulator/result width (signed), matches the MAC z width
MAC_LAT, 3, cycles from a registered mac_a/mac_b beat to its contribution appearing on mac_z
CNTW, 8, width of the per-vector beat counter

Ports:
clk  in  1  clock; all logic on the rising edge
reset  in  1  synchronous, active-high reset
s_valid  in  1  operand pair valid
s_ready  out  1  block accepts an operand pair
s_a  in  DW  signed operand a
s_b  in  DW  signed operand b
s_last  in  1  final pair of the current vector
mac_a  out  DW  registered operand to MAC a
mac_b  out  DW  registered operand to MAC b
mac_reset  out  1  registered clear to MAC reset
mac_z  in  ACCW  MAC output z
m_valid  out  1  result valid
m_ready  in  1  downstream accepts the result
m_z  out  ACCW  signed dot-product result
m_count  out  CNTW  number of pairs in the vector, saturating at 2^CNTW-1

Behaviour:
- Clock is clk; reset is synchronous, active-high.
- Reset values: state=ACCUM, first=1, mac_a=0, mac_b=0, mac_reset=1 (clears the MAC accumulator during reset), m_valid=0, m_z=0, m_count=0, s_ready=0 in the reset cycle.
- The FSM has three states: ACCUM, DRAIN, RESULT.
- ACCUM:
  - s_ready=1.
  - On a beat (s_valid & s_ready): mac_a<=s_a, mac_b<=s_b, mac_reset<=first, first<=0, and the beat counter increments with saturation (it loads 1 if first).
  - On a non-beat cycle: mac_a<=0, mac_b<=0, mac_reset<=0. Bubbles add zero products, and the vector resumes on the next beat.
  - A beat with s_last=1 moves to DRAIN and loads the drain counter with MAC_LAT.
- DRAIN:
  - s_ready=0; mac_a=mac_b=0; mac_reset=0.
  - The counter decrements each cycle. At 0 the block captures m_z<=mac_z and m_count<=beat count, sets m_valid<=1, and moves to RESULT.
- Latency: if the last beat is accepted at edge E0, m_valid is 1 after edge E0+MAC_LAT+1 (edge E4 at defaults).
- RESULT:
  - s_ready=0.
  - m_z and m_count are held stable while m_valid=1 and m_ready=0.
  - On m_valid & m_ready: m_valid<=0, first<=1, move to ACCUM.
  - m_valid drops one edge after the handshake. s_ready rises in the cycle after the handshake, never in the same cycle.
- Clear alignment: mac_reset=1 is always registered together with the first pair of a vector. The MAC clears its accumulator on the same edge it loads that pair, so the pair is accumulated from zero.
- Arithmetic: no widening. The result wraps modulo 2^ACCW, exactly as the MAC does. Overflow is not flagged.
- A single-beat vector (first beat has s_last=1) is legal: m_z = a*b and m_count = 1.
- Reset mid-vector or mid-drain:
  - The vector is abandoned and no result is emitted.
  - mac_reset=1 during reset guarantees the next vector starts clean.
- Reset while m_valid=1: the result is dropped and m_valid=0 on the next edge.
- s_a, s_b and s_last are ignored whenever s_ready=0.

Decomposition:
- Shared package mac_pkg holds: the DW/ACCW defaults, the MAC_LAT constant, and the state enum type mac_seq_state_t (ACCUM, DRAIN, RESULT).
- No sub-module. The drain counter and beat counter are inline.
- The testbench instantiates mac_seq with the existing MAC unit as the mac_a/mac_b/mac_reset/mac_z partner.

Test Plan:
- Vector (3,4),(-2,5),(7,-1) back-to-back with m_ready=1 -> m_z=16'hFFFB (-5), m_count=3, m_valid high exactly 4 cycles after the last accept edge.
- The same vector with 2 idle cycles between beats -> identical m_z=-5 and m_count=3, with mac_a=mac_b=0 on the idle cycles.
- Three beats of (-128,-128) -> m_z=16'hC000 (49152 wraps to -16384), m_count=3.
- Single beat (-1,1) with s_last=1, m_ready held low for 5 cycles -> m_z=16'hFFFF and m_count=1 stay stable, s_ready=0 throughout; after the handshake, s_ready=1 the next cycle and the next vector (2,2) yields m_z=4 (no residue from the prior vector).
- Reset asserted after 2 beats of (10,10), then vector (1,1) last -> no result for the aborted vector; next result m_z=1, m_count=1.
- 300 beats of (1,1) -> m_z=300, m_count=255 (saturated).
